// File: rtl/keypad_pkg.sv
// Shared types, constants and the telephone-pad key map for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } state_e;

    // Code shown on KEY_CODE before any key has been captured.
    localparam int unsigned IDLE_CODE = 13;

    // Telephone layout for a 4x3 pad: rows 1-2-3 / 4-5-6 / 7-8-9 / 10-0-11.
    function automatic int unsigned tel_map(input int unsigned drv, input int unsigned sns);
        int unsigned code;
        if (drv == 3) begin
            if (sns == 0) begin
                code = 10;
            end else if (sns == 1) begin
                code = 0;
            end else begin
                code = 11;
            end
        end else begin
            code = drv * 3 + sns + 1;
        end
        return code;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running sample-tick generator: one-cycle enable every SCAN_DIV clocks, with restart.
module scan_tick #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(SCAN_DIV - 1));

    // Divider counter; wraps on tick and realigns whenever the drive line changes.
    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotating one-hot drive, synchronized sense sampling, press/release
// debounce and a single-entry key-code buffer with VALID/ACK handshake and overrun flag.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_DRV      = 4,
    parameter int unsigned NUM_SNS      = 3,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned MAP_MODE     = 1,
    parameter int unsigned CODE_W       = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SNS-1:0] SNS,
    output logic [NUM_DRV-1:0] DRV,
    output logic [CODE_W-1:0]  KEY_CODE,
    output logic               KEY_VALID,
    input  logic               KEY_ACK,
    output logic               PRESS,
    output logic               OVERRUN,
    input  logic               OVR_CLR
);

    localparam int unsigned DW = $clog2(NUM_DRV);
    localparam int unsigned SW = (NUM_SNS > 1) ? $clog2(NUM_SNS) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

    logic [NUM_SNS-1:0] sns_meta;
    logic [NUM_SNS-1:0] sns_sync;
    state_e             state_q;
    logic [DW-1:0]      drv_idx_q;
    logic [SW-1:0]      cand_q;
    logic [CW-1:0]      cnt_q;
    logic               tick;
    logic               sns_any;
    logic [SW-1:0]      sns_idx;
    logic [CW-1:0]      cnt_inc;
    logic               cnt_done;
    logic               match;
    logic               press_issue;
    logic               drv_step;
    logic [CODE_W-1:0]  issue_code;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk     (CLK),
        .rst     (RST),
        .restart (drv_step),
        .tick    (tick)
    );

    // Two-flop synchronizer for the asynchronous sense pins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sns_meta <= '0;
            sns_sync <= '0;
        end else begin
            sns_meta <= SNS;
            sns_sync <= sns_meta;
        end
    end

    // Lowest-index asserted sense line wins.
    always_comb begin
        sns_idx = '0;
        for (int i = NUM_SNS - 1; i >= 0; i--) begin
            if (sns_sync[i]) begin
                sns_idx = SW'(i);
            end
        end
    end

    assign sns_any  = |sns_sync;
    assign cnt_inc  = cnt_q + CW'(1);
    assign cnt_done = (cnt_inc == CW'(DEBOUNCE_CNT));
    assign match    = sns_any && (sns_idx == cand_q);

    // Tick-qualified events shared by the FSM, the tick restart and the output buffer.
    // cnt_q is always zero in StScan, so cnt_done there means a one-tick debounce.
    always_comb begin
        press_issue = 1'b0;
        drv_step    = 1'b0;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (!sns_any) begin
                        drv_step = 1'b1;
                    end else if (cnt_done) begin
                        press_issue = 1'b1;
                    end
                end
                StDebounce: begin
                    if (!match) begin
                        drv_step = 1'b1;
                    end else if (cnt_done) begin
                        press_issue = 1'b1;
                    end
                end
                StHeld: begin
                    if (!sns_any && cnt_done) begin
                        drv_step = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key code for the current drive line and winning sense line.
    always_comb begin
        if (MAP_MODE == 1) begin
            issue_code = CODE_W'(tel_map(32'(drv_idx_q), 32'(sns_idx)));
        end else begin
            issue_code = CODE_W'(32'(drv_idx_q) * NUM_SNS + 32'(sns_idx));
        end
    end

    // Scan/debounce/held FSM with drive rotator and shared debounce/release counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StScan;
            DRV       <= NUM_DRV'(1);
            drv_idx_q <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            PRESS     <= 1'b0;
        end else if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (sns_any) begin
                        cand_q <= sns_idx;
                        if (cnt_done) begin
                            state_q <= StHeld;
                            PRESS   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StDebounce;
                            cnt_q   <= cnt_inc;
                        end
                    end
                end
                StDebounce: begin
                    if (!match) begin
                        state_q <= StScan;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= StHeld;
                        PRESS   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StHeld: begin
                    if (sns_any) begin
                        cnt_q <= '0;
                    end else if (cnt_done) begin
                        state_q <= StScan;
                        PRESS   <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StScan;
            endcase
            if (drv_step) begin
                DRV       <= {DRV[NUM_DRV-2:0], DRV[NUM_DRV-1]};
                drv_idx_q <= (drv_idx_q == DW'(NUM_DRV - 1)) ? '0 : drv_idx_q + DW'(1);
            end
        end
    end

    // Output buffer and handshake; runs every cycle. A new overrun beats OVR_CLR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            KEY_CODE  <= CODE_W'(IDLE_CODE);
            KEY_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (press_issue) begin
                if (!KEY_VALID || KEY_ACK) begin
                    KEY_CODE  <= issue_code;
                    KEY_VALID <= 1'b1;
                end
            end else if (KEY_ACK && KEY_VALID) begin
                KEY_VALID <= 1'b0;
            end
            if (press_issue && KEY_VALID && !KEY_ACK) begin
                OVERRUN <= 1'b1;
            end else if (OVR_CLR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule
